// File: rtl/trd_sched.sv
// -----------------------------------------------------------------------------
// trd_sched
//
// Purpose:
//   This block holds the per-thread PC register file and the round-robin fetch
//   scheduler for the 8-thread core. It keeps the eight architectural PCs and
//   applies the PC selector's nxt_pc_* / pc_wr updates. It tracks which threads
//   are blocked on an outstanding I- or D-miss. Each cycle it presents the next
//   ready thread and that thread's PC to fetch.
//
// Ports:
//   clk             - single clock
//   rst             - synchronous, active-high reset
//   nxt_pc_0..7     - next-PC value for each thread
//   pc_wr[7:0]      - per-thread PC write enable
//   stall           - freezes thread selection
//   i_miss/_trd     - I-cache miss for a thread (blocks it)
//   d_miss/_trd     - D-cache miss for a thread (blocks it)
//   miss_done/_trd  - refill complete (unblocks that thread)
//   trd_en[7:0]     - thread enable mask
//   cur_trd[2:0]    - thread selected for fetch
//   cur_pc[31:0]    - PC of cur_trd
//   i_rd            - fetch valid
//   trd_blk[7:0]    - registered blocked-thread mask
// -----------------------------------------------------------------------------
module trd_sched #(
    parameter int          NUM_TRD  = 8,
    parameter logic [31:0] START_PC = 32'h0001_0100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        nxt_pc_0,
    input  logic [31:0]        nxt_pc_1,
    input  logic [31:0]        nxt_pc_2,
    input  logic [31:0]        nxt_pc_3,
    input  logic [31:0]        nxt_pc_4,
    input  logic [31:0]        nxt_pc_5,
    input  logic [31:0]        nxt_pc_6,
    input  logic [31:0]        nxt_pc_7,
    input  logic [NUM_TRD-1:0] pc_wr,
    input  logic               stall,
    input  logic               i_miss,
    input  logic [2:0]         i_miss_trd,
    input  logic               d_miss,
    input  logic [2:0]         d_miss_trd,
    input  logic               miss_done,
    input  logic [2:0]         miss_done_trd,
    input  logic [NUM_TRD-1:0] trd_en,
    output logic [2:0]         cur_trd,
    output logic [31:0]        cur_pc,
    output logic               i_rd,
    output logic [NUM_TRD-1:0] trd_blk
);

    // Architectural state
    logic [31:0]        r_pc [NUM_TRD];
    logic [NUM_TRD-1:0] r_blk;
    logic [2:0]         r_cur_trd;
    logic [31:0]        r_cur_pc;
    logic               r_i_rd;
    // Set from reset until the first successful selection. While it is set
    // the search starts at thread 0 instead of cur_trd+1.
    logic               r_first;

    // Combinational helpers
    logic [31:0]        w_nxt_pc  [NUM_TRD];
    logic [31:0]        w_pc_upd  [NUM_TRD];
    logic [NUM_TRD-1:0] w_set_mask;
    logic [NUM_TRD-1:0] w_clr_mask;
    logic [NUM_TRD-1:0] w_blk_nxt;
    logic [NUM_TRD-1:0] w_rdy;
    logic [2:0]         w_origin;
    logic [2:0]         w_idx;
    logic [2:0]         w_sel;
    logic               w_found;

    assign w_nxt_pc[0] = nxt_pc_0;
    assign w_nxt_pc[1] = nxt_pc_1;
    assign w_nxt_pc[2] = nxt_pc_2;
    assign w_nxt_pc[3] = nxt_pc_3;
    assign w_nxt_pc[4] = nxt_pc_4;
    assign w_nxt_pc[5] = nxt_pc_5;
    assign w_nxt_pc[6] = nxt_pc_6;
    assign w_nxt_pc[7] = nxt_pc_7;

    // Per-thread decode of the miss/refill IDs. Each thread also gets its
    // post-write PC, which is both the next register value and the
    // same-cycle bypass value for selection.
    generate
        for (genvar gi = 0; gi < NUM_TRD; gi++) begin : g_trd
            assign w_set_mask[gi] = (i_miss && (i_miss_trd == 3'(gi))) ||
                                    (d_miss && (d_miss_trd == 3'(gi)));
            assign w_clr_mask[gi] = miss_done && (miss_done_trd == 3'(gi));
            assign w_pc_upd[gi]   = pc_wr[gi] ? w_nxt_pc[gi] : r_pc[gi];
        end
    endgenerate

    // A set wins over a clear on the same thread in the same cycle.
    assign w_blk_nxt = (r_blk & ~w_clr_mask) | w_set_mask;
    assign w_rdy     = trd_en & ~w_blk_nxt;

    // Rotating priority search: the first ready thread at or after w_origin.
    always_comb begin
        w_origin = r_first ? 3'd0 : (r_cur_trd + 3'd1);
        w_sel    = 3'd0;
        w_found  = 1'b0;
        w_idx    = 3'd0;
        for (int k = 0; k < NUM_TRD; k++) begin
            w_idx = w_origin + k[2:0];
            if (!w_found && w_rdy[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // PC file: writes land regardless of stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_TRD; k++) begin
                r_pc[k] <= START_PC;
            end
        end else begin
            for (int k = 0; k < NUM_TRD; k++) begin
                r_pc[k] <= w_pc_upd[k];
            end
        end
    end

    // Block mask
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk <= '0;
        end else begin
            r_blk <= w_blk_nxt;
        end
    end

    // Selection / fetch outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_trd <= 3'd0;
            r_cur_pc  <= START_PC;
            r_i_rd    <= 1'b0;
            r_first   <= 1'b1;
        end else if (stall) begin
            // Thread frozen, but a redirect of the current thread still lands
            // so that fetch resumes at the right address.
            if (pc_wr[r_cur_trd]) begin
                r_cur_pc <= w_nxt_pc[r_cur_trd];
            end
            r_i_rd <= r_i_rd & w_rdy[r_cur_trd];
        end else if (w_found) begin
            r_cur_trd <= w_sel;
            r_cur_pc  <= w_pc_upd[w_sel];
            r_i_rd    <= 1'b1;
            r_first   <= 1'b0;
        end else begin
            r_i_rd <= 1'b0;
        end
    end

    assign cur_trd = r_cur_trd;
    assign cur_pc  = r_cur_pc;
    assign i_rd    = r_i_rd;
    assign trd_blk = r_blk;

endmodule

// File: tb/tb_trd_sched.sv
module tb_trd_sched;

    localparam logic [31:0] SP = 32'h0001_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] nxt_pc [8];
    logic [7:0]  pc_wr;
    logic        stall;
    logic        i_miss;
    logic [2:0]  i_miss_trd;
    logic        d_miss;
    logic [2:0]  d_miss_trd;
    logic        miss_done;
    logic [2:0]  miss_done_trd;
    logic [7:0]  trd_en;
    logic [2:0]  cur_trd;
    logic [31:0] cur_pc;
    logic        i_rd;
    logic [7:0]  trd_blk;

    always #5 clk = ~clk;

    trd_sched dut (
        .clk           (clk),
        .rst           (rst),
        .nxt_pc_0      (nxt_pc[0]),
        .nxt_pc_1      (nxt_pc[1]),
        .nxt_pc_2      (nxt_pc[2]),
        .nxt_pc_3      (nxt_pc[3]),
        .nxt_pc_4      (nxt_pc[4]),
        .nxt_pc_5      (nxt_pc[5]),
        .nxt_pc_6      (nxt_pc[6]),
        .nxt_pc_7      (nxt_pc[7]),
        .pc_wr         (pc_wr),
        .stall         (stall),
        .i_miss        (i_miss),
        .i_miss_trd    (i_miss_trd),
        .d_miss        (d_miss),
        .d_miss_trd    (d_miss_trd),
        .miss_done     (miss_done),
        .miss_done_trd (miss_done_trd),
        .trd_en        (trd_en),
        .cur_trd       (cur_trd),
        .cur_pc        (cur_pc),
        .i_rd          (i_rd),
        .trd_blk       (trd_blk)
    );

    typedef struct {
        logic        rst;
        logic [7:0]  en;
        logic        stall;
        logic        im;
        logic [2:0]  imt;
        logic        dm;
        logic [2:0]  dmt;
        logic        md;
        logic [2:0]  mdt;
        logic [7:0]  wr;
        logic [31:0] nxt;
        logic        lb;     // PC-selector loopback on thread 2
        logic [2:0]  e_trd;
        logic [31:0] e_pc;
        logic        e_ird;
        logic [7:0]  e_blk;
    } vec_t;

    typedef struct {
        int          id;
        logic [2:0]  trd;
        logic [31:0] pc;
        logic        ird;
        logic [7:0]  blk;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic add(input logic r, input logic [7:0] en, input logic st,
                       input logic im, input logic [2:0] imt,
                       input logic dm, input logic [2:0] dmt,
                       input logic md, input logic [2:0] mdt,
                       input logic [7:0] wr, input logic [31:0] nxt, input logic lb,
                       input logic [2:0] et, input logic [31:0] ep,
                       input logic ei, input logic [7:0] eb);
        vec_t v;
        v.rst = r; v.en = en; v.stall = st;
        v.im = im; v.imt = imt; v.dm = dm; v.dmt = dmt; v.md = md; v.mdt = mdt;
        v.wr = wr; v.nxt = nxt; v.lb = lb;
        v.e_trd = et; v.e_pc = ep; v.e_ird = ei; v.e_blk = eb;
        vecs.push_back(v);
    endtask

    // Plain rotation step: all enabled, no events.
    task automatic addn(input logic [2:0] et, input logic [31:0] ep, input logic [7:0] eb);
        add(0, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 0, et, ep, 1, eb);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        exp_t e;
        @(negedge clk);
        rst           = v.rst;
        trd_en        = v.en;
        stall         = v.stall;
        i_miss        = v.im;
        i_miss_trd    = v.imt;
        d_miss        = v.dm;
        d_miss_trd    = v.dmt;
        miss_done     = v.md;
        miss_done_trd = v.mdt;
        pc_wr         = v.wr;
        for (int t = 0; t < 8; t++) nxt_pc[t] = v.nxt;
        if (v.lb) begin
            pc_wr[2]  = i_rd;
            nxt_pc[2] = cur_pc + 32'd1;
        end
        e.id = id; e.trd = v.e_trd; e.pc = v.e_pc; e.ird = v.e_ird; e.blk = v.e_blk;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL scoreboard_empty vec %0d", id);
        end else begin
            e = exp_q.pop_front();
            n_checks++;
            if (cur_trd !== e.trd) begin
                n_errors++;
                $display("FAIL cur_trd vec %0d: got %0d expected %0d", e.id, cur_trd, e.trd);
            end
            n_checks++;
            if (cur_pc !== e.pc) begin
                n_errors++;
                $display("FAIL cur_pc vec %0d: got %h expected %h", e.id, cur_pc, e.pc);
            end
            n_checks++;
            if (i_rd !== e.ird) begin
                n_errors++;
                $display("FAIL i_rd vec %0d: got %b expected %b", e.id, i_rd, e.ird);
            end
            n_checks++;
            if (trd_blk !== e.blk) begin
                n_errors++;
                $display("FAIL trd_blk vec %0d: got %h expected %h", e.id, trd_blk, e.blk);
            end
            $display("vec %0d: rst=%b en=%h stall=%b wr=%h -> trd=%0d pc=%h i_rd=%b blk=%h",
                     e.id, v.rst, v.en, v.stall, pc_wr, cur_trd, cur_pc, i_rd, trd_blk);
        end
    endtask

    initial begin
        rst = 1'b1; trd_en = 8'hFF; stall = 0; pc_wr = 0;
        i_miss = 0; i_miss_trd = 0; d_miss = 0; d_miss_trd = 0;
        miss_done = 0; miss_done_trd = 0;
        for (int t = 0; t < 8; t++) nxt_pc[t] = 32'h0;

        // Reset, then full rotation 0..7,0
        add(1, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 3'd0, SP, 0, 8'h00);
        for (int t = 0; t < 8; t++) addn(3'(t), SP, 8'h00);
        addn(3'd0, SP, 8'h00);
        // D-miss on thread 3 while rotating: 2 -> 4, then refill brings 3 back
        addn(3'd1, SP, 8'h00);
        addn(3'd2, SP, 8'h00);
        add(0, 8'hFF, 0, 0, 0, 1, 3'd3, 0, 0, 8'h00, 32'h0, 0, 3'd4, SP, 1, 8'h08);
        addn(3'd5, SP, 8'h08);
        addn(3'd6, SP, 8'h08);
        addn(3'd7, SP, 8'h08);
        addn(3'd0, SP, 8'h08);
        addn(3'd1, SP, 8'h08);
        addn(3'd2, SP, 8'h08);
        add(0, 8'hFF, 0, 0, 0, 0, 0, 1, 3'd3, 8'h00, 32'h0, 0, 3'd3, SP, 1, 8'h00);
        // PC write to a non-selected thread, then same-edge bypass
        add(0, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 8'h20, 32'hABCD_0005, 0, 3'd4, SP, 1, 8'h00);
        addn(3'd5, 32'hABCD_0005, 8'h00);
        add(0, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 8'h40, 32'h0000_2222, 0, 3'd6, 32'h0000_2222, 1, 8'h00);
        addn(3'd7, SP, 8'h00);
        // Stall 3 cycles with a redirect of the current thread
        for (int k = 0; k < 3; k++)
            add(0, 8'hFF, 1, 0, 0, 0, 0, 0, 0, 8'h80, 32'h0001_0000, 0, 3'd7, 32'h0001_0000, 1, 8'h00);
        addn(3'd0, SP, 8'h00);
        // Current thread blocked during stall drops i_rd; refill resumes at cur+1
        add(0, 8'hFF, 1, 0, 0, 1, 3'd0, 0, 0, 8'h00, 32'h0, 0, 3'd0, SP, 0, 8'h01);
        add(0, 8'hFF, 0, 0, 0, 0, 0, 1, 3'd0, 8'h00, 32'h0, 0, 3'd1, SP, 1, 8'h00);
        // Only thread 5 enabled; block it; set beats clear; PC write while idle
        add(0, 8'h20, 0, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 3'd5, 32'hABCD_0005, 1, 8'h00);
        add(0, 8'h20, 0, 1, 3'd5, 0, 0, 0, 0, 8'h00, 32'h0, 0, 3'd5, 32'hABCD_0005, 0, 8'h20);
        add(0, 8'h20, 0, 1, 3'd5, 0, 0, 1, 3'd5, 8'h20, 32'h0000_0055, 0, 3'd5, 32'hABCD_0005, 0, 8'h20);
        add(0, 8'h20, 0, 0, 0, 0, 0, 1, 3'd5, 8'h00, 32'h0, 0, 3'd5, 32'h0000_0055, 1, 8'h00);
        // Single enabled thread 2 with PC-selector loopback
        add(0, 8'h04, 0, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 3'd2, SP, 1, 8'h00);
        add(0, 8'h04, 0, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 1, 3'd2, 32'h0001_0101, 1, 8'h00);
        add(0, 8'h04, 0, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 1, 3'd2, 32'h0001_0102, 1, 8'h00);
        add(0, 8'h04, 0, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 1, 3'd2, 32'h0001_0103, 1, 8'h00);
        // Block every thread, two per cycle, then reset (during a stall)
        add(0, 8'hFF, 0, 1, 3'd0, 1, 3'd1, 0, 0, 8'h00, 32'h0, 0, 3'd3, SP, 1, 8'h03);
        add(0, 8'hFF, 0, 1, 3'd2, 1, 3'd3, 0, 0, 8'h00, 32'h0, 0, 3'd4, SP, 1, 8'h0F);
        add(0, 8'hFF, 0, 1, 3'd4, 1, 3'd5, 0, 0, 8'h00, 32'h0, 0, 3'd6, 32'h0000_2222, 1, 8'h3F);
        add(0, 8'hFF, 0, 1, 3'd6, 1, 3'd7, 0, 0, 8'h00, 32'h0, 0, 3'd6, 32'h0000_2222, 0, 8'hFF);
        add(1, 8'hFF, 1, 1, 3'd0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 3'd0, SP, 0, 8'h00);
        // Every PC is back at START_PC
        for (int t = 0; t < 8; t++) addn(3'(t), SP, 8'h00);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Hand-written: after reset nothing enabled, then thread 0 comes
        // up first, then normal rotation from cur_trd+1 with wrap.
        vecs.delete();
        add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 3'd0, SP, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 3'd0, SP, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 3'd0, SP, 0, 8'h00);
        add(0, 8'h01, 0, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 3'd0, SP, 1, 8'h00);
        add(0, 8'h03, 0, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 3'd1, SP, 1, 8'h00);
        add(0, 8'h03, 0, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 3'd0, SP, 1, 8'h00);
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], 1000 + i);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trd_sched.md
# trd_sched

Per-thread PC register file and round-robin fetch-thread scheduler for the 8-thread core. It holds the eight architectural PCs, applies the `nxt_pc_*` / `pc_wr` updates produced by the PC selector, and tracks which threads are blocked on an outstanding I- or D-miss. Each cycle it picks the next ready thread and presents `cur_trd` / `cur_pc` / `i_rd` to fetch. It is the consumer of the PC selector's outputs and the producer of its `cur_trd` / `cur_pc` / `i_rd` inputs.

## Interface
- `NUM_TRD`, 8, thread count; fixed at 8 because thread IDs are 3 bits.
- `START_PC`, 32'h0001_0100, reset PC of every thread.
- `clk` input 1: the block's single clock.
- `rst` input 1: reset, synchronous and active-high.
- `nxt_pc_0` … `nxt_pc_7` input 32 each: next-PC value for thread t.
- `pc_wr` input 8: bit t writes `nxt_pc_t` into PC[t].
- `stall` input 1: pipeline stall; freezes thread selection.
- `i_miss` input 1, `i_miss_trd` input 3: I-cache miss reported for a thread.
- `d_miss` input 1, `d_miss_trd` input 3: D-cache miss reported for a thread.
- `miss_done` input 1, `miss_done_trd` input 3: refill complete; unblocks that thread.
- `trd_en` input 8: thread enable mask.
- `cur_trd` output 3: thread selected for fetch.
- `cur_pc` output 32: PC of `cur_trd`.
- `i_rd` output 1: fetch valid.
- `trd_blk` output 8: blocked-thread mask.

## Operation
- **PC file**
  - On `rst`: PC[0..7] = START_PC.
  - Otherwise PC[t] <= `nxt_pc_t` when `pc_wr[t]`, independent of `stall`.
- **Block mask `blk`**
  - On `rst`: 0.
  - Per cycle: `miss_done` clears bit `miss_done_trd`.
  - `i_miss` sets bit `i_miss_trd`; `d_miss` sets bit `d_miss_trd`.
  - Set wins over clear on the same thread in the same cycle.
  - `blk_nxt` is the mask after these updates. `trd_blk` = registered `blk`.
- **Ready mask:** `rdy = trd_en & ~blk_nxt`. A miss reported this cycle prevents that thread from being selected at this edge.
- **Selection (`!stall`)**
  - Search `rdy` starting at `(cur_trd+1) mod 8`, ascending, wrapping 7 -> 0. The first set bit is `sel`.
  - If `rdy` is non-zero: `cur_trd` <= `sel`; `cur_pc` <= (`pc_wr[sel]` ? `nxt_pc_sel` : PC[sel]), i.e. same-cycle write bypass; `i_rd` <= 1.
  - If `rdy` == 0: `i_rd` <= 0; `cur_trd` and `cur_pc` hold.
  - If only one thread is ready, it is reselected every cycle. The bypass guarantees it sees its own `cur_pc+1`.
- **Stall (`stall`)**
  - `cur_trd` holds.
  - `cur_pc` <= `nxt_pc_cur` if `pc_wr[cur_trd]`, else it holds. This lets redirects during a stall land.
  - `i_rd` <= `i_rd & rdy[cur_trd]`: it drops if the current thread became blocked or disabled.
- **Reset values:** `cur_trd`=0, `cur_pc`=START_PC, `i_rd`=0, `trd_blk`=0.
  - The rotation pointer is effectively `cur_trd`. The first post-reset search starts at thread 1.
  - Exception: `i_rd`=0 with `rdy[0]`=1 selects thread 0 first. For the search origin after reset, treat `cur_trd` as 7.
- **Out-of-range / duplicates:** all 3-bit IDs are valid. `i_miss` and `d_miss` on the same thread set one bit.

## Timing
- Selection latency: 1 cycle from `rdy` change to `cur_trd` / `i_rd`.
- PC write to visible `cur_pc`: 0 extra cycles via the bypass when that thread is selected at the same edge. Otherwise the thread reads the registered PC at any later selection.
- Block set: the thread is excluded from selection at the same edge as the miss pulse. `trd_blk` reflects it 1 cycle later.
- Unblock: `miss_done` at cycle n makes the thread eligible at the edge ending cycle n.
- `rst` has priority over all inputs and aborts any stall or outstanding miss: all blocked bits clear.

## Test plan
- **Reset, all enabled, no stall** -> after `rst` deassert: `cur_trd` = 0,1,…,7,0; `cur_pc`=32'h0001_0100 each; `i_rd`=1 from the first post-reset edge.
- **Single enabled thread**, `trd_en`=8'h04, with PC selector loopback (`nxt_pc_2`=`cur_pc+1`, `pc_wr[2]`=`i_rd`) -> `cur_trd`=2 every cycle; `cur_pc` = 0x10100, 0x10101, 0x10102…
- **`d_miss` with `d_miss_trd`=3** while rotating -> thread 3 skipped (2 -> 4) and `trd_blk[3]`=1; `miss_done_trd`=3 later -> thread 3 returns at the next rotation.
- **All threads blocked** -> `i_rd`=0 and `cur_trd` / `cur_pc` hold. Same-cycle `miss_done` and `i_miss` on thread 5 -> thread 5 remains blocked.
- **`stall` held 3 cycles** with `pc_wr[cur_trd]`=1 and `nxt_pc`=32'h0001_0000 -> `cur_trd` frozen, `cur_pc` becomes 32'h0001_0000. On release, rotation resumes at `cur_trd+1`.
- **`rst` asserted mid-miss** with `trd_blk`=8'hFF -> next cycle `trd_blk`=0, all PCs = START_PC, `i_rd`=0.
